// File: rtl/game_over_check_pkg.sv
// Shared definitions for the colour-flood game: board geometry, step budget,
// colour codes and the checker's state encoding.
package game_over_check_pkg;

    localparam int DEF_GRID_W    = 14;
    localparam int DEF_GRID_H    = 14;
    localparam int DEF_MAX_STEPS = 25;

    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_ROSE  = 3'b101;
    localparam logic [2:0] COL_CYAN  = 3'b011;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/game_over_check.sv
// Game-over checker: scans the board RAM once per check request and reports
// whether the board is uniform (win) or the step budget is used up (lose).
module game_over_check
    import game_over_check_pkg::*;
#(
    parameter int GRID_W    = DEF_GRID_W,
    parameter int GRID_H    = DEF_GRID_H,
    parameter int ADDR_W    = 8,
    parameter int STEP_W    = 5,
    parameter int MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              check,
    input  logic [STEP_W-1:0] steps,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [2:0]        rd_data,
    output logic              doneCheck,
    output logic              gameOver,
    output logic              win,
    output state_t            o_dbg_state
);

    localparam int                N          = GRID_W * GRID_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
    localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

    state_t              r_state;
    logic [STEP_W-1:0]   r_steps;
    logic [2:0]          r_ref;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_cmp_addr;
    logic                r_cmp_vld;
    logic                r_done;
    logic                r_game_over;
    logic                r_win;

    wire w_cmp_first = (r_cmp_addr == '0);
    wire w_cmp_last  = (r_cmp_addr == LAST_ADDR);
    wire w_match     = (rd_data == r_ref);

    // r_cmp_addr/r_cmp_vld trail the address by one edge so they tag the word
    // the 1-cycle RAM is returning on rd_data right now.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_steps     <= '0;
            r_ref       <= '0;
            r_rd_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_cmp_addr  <= '0;
            r_cmp_vld   <= 1'b0;
            r_done      <= 1'b0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
        end else if (clear) begin
            r_state     <= ST_IDLE;
            r_rd_en     <= 1'b0;
            r_cmp_vld   <= 1'b0;
            r_done      <= 1'b0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done    <= 1'b0;
                    r_cmp_vld <= 1'b0;
                    if (check) begin
                        r_steps     <= steps;
                        r_rd_addr   <= '0;
                        r_rd_en     <= 1'b1;
                        r_game_over <= 1'b0;
                        r_win       <= 1'b0;
                        r_state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    r_cmp_vld  <= r_rd_en;
                    r_cmp_addr <= r_rd_addr;
                    if (r_rd_en) begin
                        if (r_rd_addr == LAST_ADDR) r_rd_en <= 1'b0;
                        else r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                    if (r_cmp_vld) begin
                        if (w_cmp_first) r_ref <= rd_data;
                        if (!w_cmp_first && !w_match) begin
                            r_win       <= 1'b0;
                            r_game_over <= (r_steps >= STEP_LIMIT);
                            r_rd_en     <= 1'b0;
                            r_cmp_vld   <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_cmp_last) begin
                            r_win       <= 1'b1;
                            r_game_over <= 1'b1;
                            r_rd_en     <= 1'b0;
                            r_cmp_vld   <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_rd_en <= 1'b0;
                    if (!check) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_rd_en <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr     = r_rd_addr;
    assign rd_en       = r_rd_en;
    assign doneCheck   = r_done;
    assign gameOver    = r_game_over;
    assign win         = r_win;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_game_over_check.sv
// Directed bench for game_over_check with a behavioural 1-cycle board RAM.
module tb_game_over_check;
    import game_over_check_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clear = 1'b0;
    logic        check = 1'b0;
    logic [4:0]  steps = '0;
    logic [7:0]  rd_addr;
    logic        rd_en;
    logic [2:0]  rd_data = '0;
    logic        doneCheck;
    logic        gameOver;
    logic        win;
    state_t      dbg_state;

    logic [2:0]  mem [256];
    logic [7:0]  addr_q [$];
    int          total = 0;
    int          bad = 0;

    game_over_check dut (
        .clk         (clk),
        .resetn      (resetn),
        .clear       (clear),
        .check       (check),
        .steps       (steps),
        .rd_addr     (rd_addr),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .doneCheck   (doneCheck),
        .gameOver    (gameOver),
        .win         (win),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            addr_q.push_back(rd_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [2:0] c);
        for (int i = 0; i < 256; i++) mem[i] = c;
    endtask

    // Raises check, counts edges until doneCheck, leaves check high.
    task automatic run_scan(input string tag, input logic [4:0] st, input int exp_lat,
                            input logic exp_win, input logic exp_go, input int exp_reads);
        int lat;
        int errs;
        @(negedge clk);
        addr_q.delete();
        steps = st;
        check = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_start_go"}, gameOver, 0);
        chk({tag, "_start_rden"}, rd_en, 1);
        steps = ~st;
        lat = 0;
        while (doneCheck !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_win"}, win, exp_win);
        chk({tag, "_gameover"}, gameOver, exp_go);
        chk({tag, "_rden_done"}, rd_en, 0);
        chk({tag, "_reads"}, addr_q.size(), exp_reads);
        errs = 0;
        foreach (addr_q[i]) if (addr_q[i] != 8'(i)) errs++;
        chk({tag, "_addr_walk"}, errs, 0);
    endtask

    task automatic drop_check(input string tag, input logic exp_go);
        @(negedge clk);
        check = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_done_1cyc"}, doneCheck, 0);
        chk({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
        chk({tag, "_go_hold"}, gameOver, exp_go);
    endtask

    initial begin
        fill(COL_CYAN);
        #1;
        chk("rst_rden", rd_en, 0);
        chk("rst_addr", rd_addr, 0);
        chk("rst_done", doneCheck, 0);
        chk("rst_go", gameOver, 0);
        chk("rst_win", win, 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // uniform CYAN board
        run_scan("cyan", 5'd3, 197, 1'b1, 1'b1, 196);
        drop_check("cyan", 1'b1);

        // single ROSE cell at index 5, under budget
        fill(COL_BLUE);
        mem[5] = COL_ROSE;
        run_scan("rose10", 5'd10, 7, 1'b0, 1'b0, 7);
        drop_check("rose10", 1'b0);

        // same board, budget reached; then hold check past done
        run_scan("rose25", 5'd25, 7, 1'b0, 1'b1, 7);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_done", doneCheck, 1);
        end
        chk("hold_no_reads", addr_q.size(), 7);
        chk("hold_rden", rd_en, 0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        chk("clear_go", gameOver, 0);
        chk("clear_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("clear_done", doneCheck, 0);
        @(posedge clk);
        #1;
        chk("clear_check_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("clear_check_rden", rd_en, 0);
        @(negedge clk);
        clear = 1'b0;
        check = 1'b0;

        // illegal codes compared exactly; mismatch on the last cell, one step short
        fill(3'b000);
        mem[195] = 3'b100;
        run_scan("last", 5'd24, 197, 1'b0, 1'b0, 196);
        drop_check("last", 1'b0);

        // reset in the middle of a uniform scan
        fill(COL_WHITE);
        @(negedge clk);
        steps = 5'd3;
        check = 1'b1;
        @(posedge clk);
        repeat (50) @(posedge clk);
        #1;
        resetn = 1'b0;
        check = 1'b0;
        #1;
        chk("mid_rst_rden", rd_en, 0);
        chk("mid_rst_addr", rd_addr, 0);
        chk("mid_rst_done", doneCheck, 0);
        chk("mid_rst_win", win, 0);
        chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        resetn = 1'b1;
        fill(3'b110);
        run_scan("rescan", 5'd0, 197, 1'b1, 1'b1, 196);
        drop_check("rescan", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
